// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-client main-memory arbiter.
//   - arb_state_e : arbiter FSM encoding (IDLE / SERVE / RELEASE)
//   - cli_e       : client identifier (I-cache / D-cache)
//   - ADDR_W      : memory block address width
//   - DATA_W      : memory block data width
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  typedef enum logic {
    CLI_I = 1'b0,
    CLI_D = 1'b1
  } cli_e;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_rr.sv
// -----------------------------------------------------------------------------
// mem_arb_rr
// Purely combinational 2-way round-robin picker.
// Ports:
//   pending_i_i    in   I-cache has a request pending
//   pending_d_i    in   D-cache has a request pending
//   last_grant_i   in   client that received the most recent grant
//   grant_valid_o  out  at least one client is pending
//   grant_id_o     out  client to grant (only meaningful with grant_valid_o)
// -----------------------------------------------------------------------------
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic pending_i_i,
  input  logic pending_d_i,
  input  cli_e last_grant_i,
  output logic grant_valid_o,
  output cli_e grant_id_o
);

  always_comb begin
    grant_valid_o = pending_i_i | pending_d_i;
    grant_id_o    = CLI_I;
    if (pending_i_i && pending_d_i) begin
      // Tie: favour whichever client was not served last.
      grant_id_o = (last_grant_i == CLI_I) ? CLI_D : CLI_I;
    end else if (pending_d_i) begin
      grant_id_o = CLI_D;
    end
  end

endmodule : mem_arb_rr

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single 128-bit main-memory port between the I-cache and the
// D-cache. One request is granted at a time with round-robin fairness; the
// winning request is registered toward memory, the memory handshake is routed
// back to the granted cache, and per-client saturating grant counters are kept.
//
// Ports:
//   clk            in   system clock (rising edge)
//   proc_reset_n   in   asynchronous active-low reset
//   i_mem_read     in   I-cache read strobe, held until i_mem_ready
//   i_mem_write    in   I-cache write strobe, held until i_mem_ready
//   i_mem_addr     in   I-cache block address
//   i_mem_wdata    in   I-cache write block
//   i_mem_rdata    out  read block to I-cache (always mem_rdata)
//   i_mem_ready    out  one-cycle completion pulse to I-cache
//   d_mem_*        same set for the D-cache
//   mem_read       out  registered read request to memory
//   mem_write      out  registered write request to memory
//   mem_addr       out  registered block address to memory
//   mem_wdata      out  registered write block to memory
//   mem_rdata      in   read block from memory
//   mem_ready      in   memory completion pulse
//   i_grant_cnt    out  saturating count of I-cache grants
//   d_grant_cnt    out  saturating count of D-cache grants
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              proc_reset_n,

  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,

  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,

  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt
);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (&v) ? v : (v + one);
  endfunction

  arb_state_e        state_q, state_d;
  cli_e              grant_q, last_q;
  logic              rd_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  icnt_q, dcnt_q;

  logic              pending_i, pending_d;
  logic              grant_valid;
  cli_e              grant_id;
  logic              grant_fire;
  logic              serve_done;

  logic              sel_rd, sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign pending_i = i_mem_read | i_mem_write;
  assign pending_d = d_mem_read | d_mem_write;

  mem_arb_rr u_rr (
    .pending_i_i   (pending_i),
    .pending_d_i   (pending_d),
    .last_grant_i  (last_q),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  // Grants are only issued from IDLE; RELEASE exists so a served cache can
  // drop its strobe before the picker looks at it again.
  assign grant_fire = (state_q == ST_IDLE)  && grant_valid;
  // mem_ready outside SERVE is ignored.
  assign serve_done = (state_q == ST_SERVE) && mem_ready;

  // Request fields of the winning client.
  always_comb begin
    sel_rd    = i_mem_read;
    sel_wr    = i_mem_write;
    sel_addr  = i_mem_addr;
    sel_wdata = i_mem_wdata;
    if (grant_id == CLI_D) begin
      sel_rd    = d_mem_read;
      sel_wr    = d_mem_write;
      sel_addr  = d_mem_addr;
      sel_wdata = d_mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (grant_valid) state_d = ST_SERVE;
      ST_SERVE:   if (mem_ready)   state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (completion routed combinationally to the granted cache)
  // ---------------------------------------------------------------------------
  always_comb begin
    i_mem_ready = 1'b0;
    d_mem_ready = 1'b0;
    if (serve_done) begin
      if (grant_q == CLI_D) d_mem_ready = 1'b1;
      else                  d_mem_ready = 1'b0;
      i_mem_ready = (grant_q == CLI_I);
    end
  end

  // ---------------------------------------------------------------------------
  // Request capture toward memory, grant bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      grant_q <= CLI_I;
      last_q  <= CLI_I;
    end else if (grant_fire) begin
      // A client asserting both strobes gets a write; the read is dropped.
      wr_q    <= sel_wr;
      rd_q    <= sel_rd & ~sel_wr;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
      grant_q <= grant_id;
      last_q  <= grant_id;
    end else if (serve_done) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating grant counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      icnt_q <= '0;
      dcnt_q <= '0;
    end else if (grant_fire) begin
      if (grant_id == CLI_I) icnt_q <= sat_inc(icnt_q);
      else                   dcnt_q <= sat_inc(dcnt_q);
    end
  end

  assign mem_read    = rd_q;
  assign mem_write   = wr_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;

  // Both caches see the memory read bus; only the readied one samples it.
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

  assign i_grant_cnt = icnt_q;
  assign d_grant_cnt = dcnt_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. Expected memory requests and expected
// cache completions are queued in the order they must appear; a monitor pops
// and compares whenever the DUT starts a memory request or pulses a ready.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Counters use CNT_W=2 so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int CNT_W = 2;

  logic         clk;
  logic         proc_reset_n;
  logic         i_mem_read, i_mem_write;
  logic [27:0]  i_mem_addr;
  logic [127:0] i_mem_wdata, i_mem_rdata;
  logic         i_mem_ready;
  logic         d_mem_read, d_mem_write;
  logic [27:0]  d_mem_addr;
  logic [127:0] d_mem_wdata, d_mem_rdata;
  logic         d_mem_ready;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;
  logic [CNT_W-1:0] i_grant_cnt, d_grant_cnt;

  logic mdl_rdy, inj_rdy;
  assign mem_ready = mdl_rdy | inj_rdy;

  int npass = 0;
  int ntot  = 0;
  int mem_lat = 4;

  typedef struct packed {
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } req_t;

  typedef struct packed {
    logic         cli;
    logic [127:0] rdata;
  } rdy_t;

  req_t exp_req_q[$];
  rdy_t exp_rdy_q[$];

  mem_arbiter #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .i_mem_read   (i_mem_read),
    .i_mem_write  (i_mem_write),
    .i_mem_addr   (i_mem_addr),
    .i_mem_wdata  (i_mem_wdata),
    .i_mem_rdata  (i_mem_rdata),
    .i_mem_ready  (i_mem_ready),
    .d_mem_read   (d_mem_read),
    .d_mem_write  (d_mem_write),
    .d_mem_addr   (d_mem_addr),
    .d_mem_wdata  (d_mem_wdata),
    .d_mem_rdata  (d_mem_rdata),
    .d_mem_ready  (d_mem_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .i_grant_cnt  (i_grant_cnt),
    .d_grant_cnt  (d_grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns a block tagged with the address it was asked for.
  function automatic logic [127:0] rd_of(input logic [27:0] a);
    return {68'h0, a, 32'hDEAD_BEEF};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h want=%0h", nm, got, exp);
  endtask

  task automatic push_req(input logic wr, input logic [27:0] a, input logic [127:0] wd);
    req_t r;
    r.wr = wr; r.addr = a; r.wdata = wd;
    exp_req_q.push_back(r);
  endtask

  task automatic push_rdy(input logic cli, input logic [27:0] a);
    rdy_t r;
    r.cli = cli; r.rdata = rd_of(a);
    exp_rdy_q.push_back(r);
  endtask

  task automatic drive(input bit cli, input logic rd, input logic wr,
                       input logic [27:0] a, input logic [127:0] wd);
    if (cli) begin
      d_mem_read = rd; d_mem_write = wr; d_mem_addr = a; d_mem_wdata = wd;
    end else begin
      i_mem_read = rd; i_mem_write = wr; i_mem_addr = a; i_mem_wdata = wd;
    end
  endtask

  // Waits (bounded) on falling edges until the given client sees ready.
  task automatic wait_rdy(input bit cli, input string nm);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (cli ? d_mem_ready : i_mem_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      ntot++;
      $display("FAIL %s timeout waiting for ready cli=%0d got=0 want=1", nm, cli);
    end
  endtask

  // Cache-like transaction: raise strobe, hold until ready, drop next cycle.
  task automatic txn(input bit cli, input bit wr, input logic [27:0] a, input logic [127:0] wd);
    @(posedge clk); #1;
    drive(cli, !wr, wr, a, wd);
    wait_rdy(cli, "txn");
    @(posedge clk); #1;
    drive(cli, 1'b0, 1'b0, a, wd);
  endtask

  // Memory model: ready pulse mem_lat cycles after a request first appears.
  initial begin
    bit active;
    int wcnt;
    active = 1'b0;
    wcnt = 0;
    mdl_rdy = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mdl_rdy = 1'b0;
      if (!(mem_read || mem_write)) begin
        active = 1'b0;
      end else begin
        if (!active) begin
          active = 1'b1;
          wcnt = mem_lat - 1;
        end
        if (wcnt == 0) begin
          mdl_rdy = 1'b1;
          mem_rdata = rd_of(mem_addr);
        end else begin
          wcnt--;
        end
      end
    end
  end

  // Monitor: compares every new memory request and every ready pulse.
  initial begin
    logic prev;
    req_t er;
    rdy_t ey;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if ((mem_read || mem_write) && !prev) begin
        if (exp_req_q.size() == 0) begin
          ntot++;
          $display("FAIL mon_req unexpected request addr=%0h want none", mem_addr);
        end else begin
          er = exp_req_q.pop_front();
          chk("mon_req_wr",    mem_write, er.wr);
          chk("mon_req_rd",    mem_read,  !er.wr);
          chk("mon_req_addr",  mem_addr,  er.addr);
          chk("mon_req_wdata", mem_wdata, er.wdata);
        end
      end
      prev = mem_read || mem_write;
      if (i_mem_ready && d_mem_ready) begin
        ntot++;
        $display("FAIL mon_rdy both readies got=11 want one-hot");
      end else if (i_mem_ready || d_mem_ready) begin
        if (exp_rdy_q.size() == 0) begin
          ntot++;
          $display("FAIL mon_rdy unexpected ready i=%0d d=%0d want none", i_mem_ready, d_mem_ready);
        end else begin
          ey = exp_rdy_q.pop_front();
          chk("mon_rdy_cli", d_mem_ready, ey.cli);
          chk("mon_rdy_rdata", d_mem_ready ? d_mem_rdata : i_mem_rdata, ey.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    proc_reset_n = 1'b0;
    inj_rdy = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    chk("rst_mem_read",  mem_read,    0);
    chk("rst_mem_write", mem_write,   0);
    chk("rst_mem_addr",  mem_addr,    0);
    chk("rst_mem_wdata", mem_wdata,   0);
    chk("rst_i_ready",   i_mem_ready, 0);
    chk("rst_d_ready",   d_mem_ready, 0);
    chk("rst_i_cnt",     i_grant_cnt, 0);
    chk("rst_d_cnt",     d_grant_cnt, 0);
    proc_reset_n = 1'b1;

    // Single I read, cycle-exact timing.
    push_req(1'b0, 28'h0000010, '0);
    push_rdy(1'b0, 28'h0000010);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 28'h0000010, '0);
    @(negedge clk);
    chk("t1_c0_read", mem_read, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t1_read_hi",  mem_read,    1);
      chk("t1_addr",     mem_addr,    28'h0000010);
      chk("t1_i_ready",  i_mem_ready, (k == 4));
      chk("t1_d_ready",  d_mem_ready, 0);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t1_release_read", mem_read, 0);
    chk("t1_i_cnt", i_grant_cnt, 1);

    // Stray mem_ready while idle must not reach either cache.
    @(posedge clk); #1;
    inj_rdy = 1'b1;
    @(negedge clk);
    chk("idle_ready_i", i_mem_ready, 0);
    chk("idle_ready_d", d_mem_ready, 0);
    @(posedge clk); #1;
    inj_rdy = 1'b0;

    // First tie after reset: D wins, then I.
    push_req(1'b1, 28'h0000020, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    push_req(1'b0, 28'h0000010, '0);
    push_rdy(1'b1, 28'h0000020);
    push_rdy(1'b0, 28'h0000010);
    fork
      txn(1'b0, 1'b0, 28'h0000010, '0);
      txn(1'b1, 1'b1, 28'h0000020, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    join
    chk("t2_i_cnt", i_grant_cnt, 2);
    chk("t2_d_cnt", d_grant_cnt, 1);

    // D write-back + allocate with I pending throughout: D-wr, I-rd, D-rd.
    push_req(1'b1, 28'h0000100, 128'hA0A0_0000_0000_0000_0000_0000_0000_0B0B);
    push_req(1'b0, 28'h0000200, '0);
    push_req(1'b0, 28'h0000140, '0);
    push_rdy(1'b1, 28'h0000100);
    push_rdy(1'b0, 28'h0000200);
    push_rdy(1'b1, 28'h0000140);
    fork
      begin
        txn(1'b1, 1'b1, 28'h0000100, 128'hA0A0_0000_0000_0000_0000_0000_0000_0B0B);
        txn(1'b1, 1'b0, 28'h0000140, '0);
      end
      txn(1'b0, 1'b0, 28'h0000200, '0);
    join
    chk("t3_i_cnt", i_grant_cnt, 3);
    chk("t3_d_cnt", d_grant_cnt, 3);

    // Strobe held through RELEASE: no regrant until IDLE sees it as new.
    push_req(1'b0, 28'h0000300, '0);
    push_rdy(1'b0, 28'h0000300);
    push_req(1'b0, 28'h0000300, '0);
    push_rdy(1'b0, 28'h0000300);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 28'h0000300, '0);
    wait_rdy(1'b0, "t4_first");
    @(negedge clk);
    chk("t4_release_no_grant", mem_read, 0);
    @(negedge clk);
    chk("t4_idle_no_grant", mem_read, 0);
    @(negedge clk);
    chk("t4_regrant", mem_read, 1);
    wait_rdy(1'b0, "t4_second");
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);

    // Async reset in the middle of a D write.
    push_req(1'b1, 28'h0000500, 128'h5555);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b1, 28'h0000500, 128'h5555);
    repeat (3) @(negedge clk);
    chk("t5_pre_write", mem_write, 1);
    #2;
    proc_reset_n = 1'b0;
    #1;
    chk("t5_rst_write", mem_write,   0);
    chk("t5_rst_read",  mem_read,    0);
    chk("t5_rst_addr",  mem_addr,    0);
    chk("t5_rst_wdata", mem_wdata,   0);
    chk("t5_rst_i_cnt", i_grant_cnt, 0);
    chk("t5_rst_d_cnt", d_grant_cnt, 0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    proc_reset_n = 1'b1;
    // last_grant back to I, so the tie goes to D again.
    push_req(1'b0, 28'h0000620, '0);
    push_req(1'b0, 28'h0000610, '0);
    push_rdy(1'b1, 28'h0000620);
    push_rdy(1'b0, 28'h0000610);
    fork
      txn(1'b0, 1'b0, 28'h0000610, '0);
      txn(1'b1, 1'b0, 28'h0000620, '0);
    join
    chk("t5_post_i_cnt", i_grant_cnt, 1);
    chk("t5_post_d_cnt", d_grant_cnt, 1);

    // Counter saturation at 2^CNT_W-1.
    @(negedge clk);
    proc_reset_n = 1'b0;
    @(negedge clk);
    proc_reset_n = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      push_req(1'b0, 28'h0000700 + 28'(n), '0);
      push_rdy(1'b0, 28'h0000700 + 28'(n));
      txn(1'b0, 1'b0, 28'h0000700 + 28'(n), '0);
      chk("t6_i_cnt_sat", i_grant_cnt, (n < 3) ? n : 3);
    end
    chk("t6_d_cnt", d_grant_cnt, 0);

    repeat (4) @(negedge clk);
    chk("end_req_q_empty", exp_req_q.size(), 0);
    chk("end_rdy_q_empty", exp_rdy_q.size(), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule : tb_mem_arbiter
